// File: rtl/pc_sequencer_if.sv
// Bundle of every pc_sequencer signal except clock and reset.
//   master : sequencer side (drives fetch request, commit ready, trap/err pulses, instret)
//   slave  : environment side (IFU fetch_ready, WBU commit payload, CSR values)
interface pc_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    localparam int unsigned CNT_W = 64;
    localparam int unsigned SRC_W = 3;

    logic             fetch_valid;
    logic             fetch_ready;
    logic [XLEN-1:0]  fetch_pc;
    logic             cmt_valid;
    logic             cmt_ready;
    logic [SRC_W-1:0] cmt_pcsrc;
    logic [XLEN-1:0]  cmt_imm;
    logic [XLEN-1:0]  cmt_rs1;
    logic [XLEN-1:0]  csr_mtvec;
    logic [XLEN-1:0]  csr_mepc;
    logic             trap_valid;
    logic [XLEN-1:0]  trap_tval;
    logic             pcsrc_err;
    logic [CNT_W-1:0] instret;

    modport master (
        output fetch_valid, fetch_pc, cmt_ready, trap_valid, trap_tval, pcsrc_err, instret,
        input  fetch_ready, cmt_valid, cmt_pcsrc, cmt_imm, cmt_rs1, csr_mtvec, csr_mepc
    );

    modport slave (
        input  fetch_valid, fetch_pc, cmt_ready, trap_valid, trap_tval, pcsrc_err, instret,
        output fetch_ready, cmt_valid, cmt_pcsrc, cmt_imm, cmt_rs1, csr_mtvec, csr_mepc
    );
endinterface

// File: rtl/pc_sequencer.sv
// Single-issue PC sequencer: owns the architectural PC, issues one fetch at a
// time, waits for its commit, computes the next PC from PCSrc, raises a
// misaligned-target redirect and counts retired instructions.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : pc_sequencer_if.master (fetch handshake, commit handshake + payload,
//           CSR inputs, trap/pcsrc_err pulses, instret)
module pc_sequencer #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
    input  logic           clock,
    input  logic           reset,
    pc_sequencer_if.master bus
);
    localparam int unsigned CNT_W = 64;
    localparam int unsigned SRC_W = 3;

    localparam logic [SRC_W-1:0] SRC_SNPC   = SRC_W'(0);
    localparam logic [SRC_W-1:0] SRC_DNPC   = SRC_W'(1);
    localparam logic [SRC_W-1:0] SRC_DNPC_R = SRC_W'(2);
    localparam logic [SRC_W-1:0] SRC_MTVEC  = SRC_W'(3);
    localparam logic [SRC_W-1:0] SRC_MEPC   = SRC_W'(4);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    state_e           state_q;
    logic [XLEN-1:0]  pc_q;
    logic             fetch_valid_q;
    logic             cmt_ready_q;
    logic             trap_valid_q;
    logic [XLEN-1:0]  trap_tval_q;
    logic             pcsrc_err_q;
    logic [CNT_W-1:0] instret_q;

    logic [XLEN-1:0]  target_c;
    logic [XLEN-1:0]  mtvec_base_c;
    logic [XLEN-1:0]  rs1_sum_c;
    logic             check_align_c;
    logic             illegal_c;
    logic             misalign_c;
    logic [XLEN-1:0]  pc_d;

    // Next-PC target selection and misalign detection for the committing instruction.
    always_comb begin
        target_c      = pc_q + XLEN'(4);
        check_align_c = 1'b0;
        illegal_c     = 1'b0;
        mtvec_base_c  = {bus.csr_mtvec[XLEN-1:2], 2'b00};
        rs1_sum_c     = bus.cmt_rs1 + bus.cmt_imm;
        unique case (bus.cmt_pcsrc)
            SRC_SNPC:   target_c = pc_q + XLEN'(4);
            SRC_DNPC: begin
                target_c      = pc_q + bus.cmt_imm;
                check_align_c = 1'b1;
            end
            SRC_DNPC_R: begin
                target_c      = {rs1_sum_c[XLEN-1:1], 1'b0};
                check_align_c = 1'b1;
            end
            SRC_MTVEC:  target_c = mtvec_base_c;
            SRC_MEPC: begin
                target_c      = bus.csr_mepc;
                check_align_c = 1'b1;
            end
            default:    illegal_c = 1'b1;
        endcase
        misalign_c = check_align_c && (target_c[1:0] != 2'b00);
        pc_d       = misalign_c ? mtvec_base_c : target_c;
    end

    // Sequencer FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            cmt_ready_q   <= 1'b0;
            trap_valid_q  <= 1'b0;
            trap_tval_q   <= '0;
            pcsrc_err_q   <= 1'b0;
            instret_q     <= '0;
        end else begin
            trap_valid_q <= 1'b0;
            pcsrc_err_q  <= 1'b0;
            unique case (state_q)
                S_BOOT: begin
                    state_q       <= S_ISSUE;
                    fetch_valid_q <= 1'b1;
                end
                S_ISSUE: begin
                    if (fetch_valid_q && bus.fetch_ready) begin
                        state_q       <= S_WAIT;
                        fetch_valid_q <= 1'b0;
                        cmt_ready_q   <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bus.cmt_valid && cmt_ready_q) begin
                        state_q       <= S_ISSUE;
                        pc_q          <= pc_d;
                        instret_q     <= instret_q + CNT_W'(1);
                        fetch_valid_q <= 1'b1;
                        cmt_ready_q   <= 1'b0;
                        trap_valid_q  <= misalign_c;
                        pcsrc_err_q   <= illegal_c;
                        if (misalign_c) begin
                            trap_tval_q <= target_c;
                        end
                    end
                end
                default: begin
                    state_q       <= S_BOOT;
                    fetch_valid_q <= 1'b0;
                    cmt_ready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_pc    = pc_q;
    assign bus.cmt_ready   = cmt_ready_q;
    assign bus.trap_valid  = trap_valid_q;
    assign bus.trap_tval   = trap_tval_q;
    assign bus.pcsrc_err   = pcsrc_err_q;
    assign bus.instret     = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: reset/boot, sequential stream,
// branch/jalr, mtvec/mepc redirects, misaligned-target traps, backpressure,
// illegal PCSrc and instret wrap.
module tb_pc_sequencer;
    localparam int unsigned XLEN = 32;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    logic [31:0] exp_pc;
    logic [63:0] exp_instret;

    pc_sequencer_if #(.XLEN(XLEN)) bus ();

    pc_sequencer #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus helpers; all driving happens at the falling edge.
    task automatic clear_inputs();
        bus.fetch_ready = 1'b0;
        bus.cmt_valid   = 1'b0;
        bus.cmt_pcsrc   = 3'd0;
        bus.cmt_imm     = '0;
        bus.cmt_rs1     = '0;
        bus.csr_mtvec   = '0;
        bus.csr_mepc    = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_pc      = RST_PC;
        exp_instret = 64'd0;
    endtask

    task automatic fetch_accept();
        bus.fetch_ready = 1'b1;
        @(negedge clk);
        bus.fetch_ready = 1'b0;
    endtask

    task automatic commit(input logic [2:0] src, input logic [31:0] imm, input logic [31:0] rs1);
        bus.cmt_valid = 1'b1;
        bus.cmt_pcsrc = src;
        bus.cmt_imm   = imm;
        bus.cmt_rs1   = rs1;
        @(negedge clk);
        bus.cmt_valid = 1'b0;
        exp_instret   = exp_instret + 64'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        tests++;
        if (bus.fetch_valid !== 1'b0 || bus.cmt_ready !== 1'b0 || bus.trap_valid !== 1'b0 ||
            bus.pcsrc_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctl: fv=%b cr=%b tv=%b pe=%b expected all 0",
                     bus.fetch_valid, bus.cmt_ready, bus.trap_valid, bus.pcsrc_err);
        end
        tests++;
        if (bus.fetch_pc !== RST_PC || bus.instret !== 64'd0 || bus.trap_tval !== 32'd0) begin
            fails++;
            $display("FAIL reset_val: pc=%h instret=%0d tval=%h expected %h 0 0",
                     bus.fetch_pc, bus.instret, bus.trap_tval, RST_PC);
        end
        rst = 1'b0;
        bus.fetch_ready = 1'b1;
        #1;
        tests++;
        if (bus.fetch_valid !== 1'b0) begin
            fails++;
            $display("FAIL boot_hold: fetch_valid=%b expected 0", bus.fetch_valid);
        end
        @(negedge clk);
        tests++;
        if (bus.fetch_valid !== 1'b1 || bus.fetch_pc !== RST_PC) begin
            fails++;
            $display("FAIL boot_issue: fv=%b pc=%h expected 1 %h", bus.fetch_valid, bus.fetch_pc, RST_PC);
        end
        bus.fetch_ready = 1'b0;
        // Reset mid-ISSUE drops fetch_valid asynchronously.
        rst = 1'b1;
        #1;
        tests++;
        if (bus.fetch_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_issue: fetch_valid=%b expected 0", bus.fetch_valid);
        end
        // Reset mid-WAIT with a pending commit discards it.
        do_reset();
        fetch_accept();
        bus.cmt_valid = 1'b1;
        bus.cmt_pcsrc = 3'd0;
        rst = 1'b1;
        #1;
        tests++;
        if (bus.cmt_ready !== 1'b0 || bus.instret !== 64'd0 || bus.fetch_pc !== RST_PC) begin
            fails++;
            $display("FAIL reset_wait: cr=%b instret=%0d pc=%h expected 0 0 %h",
                     bus.cmt_ready, bus.instret, bus.fetch_pc, RST_PC);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.fetch_valid !== 1'b1 || bus.cmt_ready !== 1'b0 || bus.instret !== 64'd0) begin
            fails++;
            $display("FAIL reset_reboot: fv=%b cr=%b instret=%0d expected 1 0 0",
                     bus.fetch_valid, bus.cmt_ready, bus.instret);
        end
        bus.cmt_valid = 1'b0;
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (bus.fetch_pc !== exp_pc || bus.fetch_valid !== 1'b1) begin
                fails++;
                $display("FAIL seq_pc%0d: pc=%h fv=%b expected %h 1", i, bus.fetch_pc, bus.fetch_valid, exp_pc);
            end
            fetch_accept();
            tests++;
            if (bus.fetch_valid !== 1'b0 || bus.cmt_ready !== 1'b1) begin
                fails++;
                $display("FAIL seq_wait%0d: fv=%b cr=%b expected 0 1", i, bus.fetch_valid, bus.cmt_ready);
            end
            commit(3'b000, 32'h0, 32'h0);
            exp_pc = exp_pc + 32'd4;
            tests++;
            if (bus.fetch_valid !== 1'b1 || bus.cmt_ready !== 1'b0) begin
                fails++;
                $display("FAIL seq_lat%0d: fv=%b cr=%b expected 1 0", i, bus.fetch_valid, bus.cmt_ready);
            end
        end
        tests++;
        if (bus.fetch_pc !== 32'h8000_000C || bus.instret !== 64'd3) begin
            fails++;
            $display("FAIL seq_end: pc=%h instret=%0d expected 8000000c 3", bus.fetch_pc, bus.instret);
        end
    endtask

    task automatic test_branch();
        fetch_accept();
        commit(3'b000, 32'h0, 32'h0);
        tests++;
        if (bus.fetch_pc !== 32'h8000_0010) begin
            fails++;
            $display("FAIL br_setup: pc=%h expected 80000010", bus.fetch_pc);
        end
        fetch_accept();
        commit(3'b001, 32'hFFFF_FFF0, 32'h0);
        tests++;
        if (bus.fetch_pc !== 32'h8000_0000 || bus.trap_valid !== 1'b0) begin
            fails++;
            $display("FAIL br_dnpc: pc=%h tv=%b expected 80000000 0", bus.fetch_pc, bus.trap_valid);
        end
        fetch_accept();
        commit(3'b010, 32'h0000_0003, 32'h8000_0101);
        tests++;
        if (bus.fetch_pc !== 32'h8000_0104 || bus.trap_valid !== 1'b0) begin
            fails++;
            $display("FAIL br_jalr: pc=%h tv=%b expected 80000104 0", bus.fetch_pc, bus.trap_valid);
        end
    endtask

    task automatic test_trap_mret();
        bus.csr_mtvec = 32'h8000_0203;
        fetch_accept();
        commit(3'b011, 32'h0, 32'h0);
        tests++;
        if (bus.fetch_pc !== 32'h8000_0200 || bus.trap_valid !== 1'b0) begin
            fails++;
            $display("FAIL mtvec: pc=%h tv=%b expected 80000200 0", bus.fetch_pc, bus.trap_valid);
        end
        bus.csr_mepc = 32'h8000_0044;
        fetch_accept();
        commit(3'b100, 32'h0, 32'h0);
        tests++;
        if (bus.fetch_pc !== 32'h8000_0044 || bus.trap_valid !== 1'b0) begin
            fails++;
            $display("FAIL mepc: pc=%h tv=%b expected 80000044 0", bus.fetch_pc, bus.trap_valid);
        end
    endtask

    task automatic test_misalign();
        fetch_accept();
        commit(3'b001, 32'hFFFF_FFBC, 32'h0);
        tests++;
        if (bus.fetch_pc !== 32'h8000_0000) begin
            fails++;
            $display("FAIL mis_setup: pc=%h expected 80000000", bus.fetch_pc);
        end
        bus.csr_mtvec = 32'h8000_0100;
        fetch_accept();
        commit(3'b001, 32'h0000_0006, 32'h0);
        tests++;
        if (bus.trap_valid !== 1'b1 || bus.trap_tval !== 32'h8000_0006 || bus.fetch_pc !== 32'h8000_0100) begin
            fails++;
            $display("FAIL mis_dnpc: tv=%b tval=%h pc=%h expected 1 80000006 80000100",
                     bus.trap_valid, bus.trap_tval, bus.fetch_pc);
        end
        tests++;
        if (bus.instret !== exp_instret) begin
            fails++;
            $display("FAIL mis_instret: instret=%0d expected %0d", bus.instret, exp_instret);
        end
        @(negedge clk);
        tests++;
        if (bus.trap_valid !== 1'b0 || bus.trap_tval !== 32'h8000_0006) begin
            fails++;
            $display("FAIL mis_pulse: tv=%b tval=%h expected 0 80000006", bus.trap_valid, bus.trap_tval);
        end
        // jalr: bit0 cleared, bit1 still misaligned.
        fetch_accept();
        commit(3'b010, 32'h0, 32'h8000_0003);
        tests++;
        if (bus.trap_valid !== 1'b1 || bus.trap_tval !== 32'h8000_0002 || bus.fetch_pc !== 32'h8000_0100) begin
            fails++;
            $display("FAIL mis_jalr: tv=%b tval=%h pc=%h expected 1 80000002 80000100",
                     bus.trap_valid, bus.trap_tval, bus.fetch_pc);
        end
        bus.csr_mepc  = 32'h8000_0046;
        bus.csr_mtvec = 32'h8000_0301;
        fetch_accept();
        commit(3'b100, 32'h0, 32'h0);
        tests++;
        if (bus.trap_valid !== 1'b1 || bus.trap_tval !== 32'h8000_0046 || bus.fetch_pc !== 32'h8000_0300) begin
            fails++;
            $display("FAIL mis_mepc: tv=%b tval=%h pc=%h expected 1 80000046 80000300",
                     bus.trap_valid, bus.trap_tval, bus.fetch_pc);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] pc0;
        logic [63:0] ir0;
        pc0 = bus.fetch_pc;
        ir0 = bus.instret;
        bus.cmt_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (bus.fetch_valid !== 1'b1 || bus.fetch_pc !== pc0 || bus.cmt_ready !== 1'b0 ||
                bus.instret !== ir0) begin
                fails++;
                $display("FAIL bp_hold%0d: fv=%b pc=%h cr=%b instret=%0d expected 1 %h 0 %0d",
                         i, bus.fetch_valid, bus.fetch_pc, bus.cmt_ready, bus.instret, pc0, ir0);
            end
        end
        bus.cmt_valid = 1'b0;
        fetch_accept();
        // fetch_ready while fetch_valid is low does nothing.
        bus.fetch_ready = 1'b1;
        @(negedge clk);
        bus.fetch_ready = 1'b0;
        tests++;
        if (bus.fetch_valid !== 1'b0 || bus.cmt_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_ready_idle: fv=%b cr=%b expected 0 1", bus.fetch_valid, bus.cmt_ready);
        end
        commit(3'b000, 32'h0, 32'h0);
        tests++;
        if (bus.fetch_pc !== pc0 + 32'd4) begin
            fails++;
            $display("FAIL bp_resume: pc=%h expected %h", bus.fetch_pc, pc0 + 32'd4);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] pc0;
        pc0 = bus.fetch_pc;
        fetch_accept();
        commit(3'b111, 32'h0000_0100, 32'h0);
        tests++;
        if (bus.pcsrc_err !== 1'b1 || bus.trap_valid !== 1'b0 || bus.fetch_pc !== pc0 + 32'd4) begin
            fails++;
            $display("FAIL ill_111: pe=%b tv=%b pc=%h expected 1 0 %h",
                     bus.pcsrc_err, bus.trap_valid, bus.fetch_pc, pc0 + 32'd4);
        end
        @(negedge clk);
        tests++;
        if (bus.pcsrc_err !== 1'b0) begin
            fails++;
            $display("FAIL ill_pulse: pe=%b expected 0", bus.pcsrc_err);
        end
        fetch_accept();
        commit(3'b101, 32'h0000_0002, 32'h0);
        tests++;
        if (bus.pcsrc_err !== 1'b1 || bus.fetch_pc !== pc0 + 32'd8) begin
            fails++;
            $display("FAIL ill_101: pe=%b pc=%h expected 1 %h", bus.pcsrc_err, bus.fetch_pc, pc0 + 32'd8);
        end
    endtask

    task automatic test_wrap();
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFE;
        @(negedge clk);
        release dut.instret_q;
        fetch_accept();
        commit(3'b000, 32'h0, 32'h0);
        tests++;
        if (bus.instret !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            fails++;
            $display("FAIL wrap_max: instret=%h expected ffffffffffffffff", bus.instret);
        end
        fetch_accept();
        commit(3'b000, 32'h0, 32'h0);
        tests++;
        if (bus.instret !== 64'd0) begin
            fails++;
            $display("FAIL wrap_zero: instret=%h expected 0", bus.instret);
        end
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        exp_pc      = RST_PC;
        exp_instret = 64'd0;
        rst         = 1'b1;
        clear_inputs();
        test_reset();
        test_sequential();
        test_branch();
        test_trap_mret();
        test_misalign();
        test_backpressure();
        test_illegal();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
